// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM encoding,
// register-file constants and the divider latency default.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO       = 5'd0;
  localparam int         DIV_CYCLES_DEF = 32;

  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  function automatic logic src_match(input logic uses, input logic [4:0] src,
                                     input logic [4:0] dst);
    return uses && (dst != REG_ZERO) && (src == dst);
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard-status inputs and stage-register control outputs of the stall sequencer.
// master = datapath side, slave = the sequencer.
interface pipe_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             mem_stall;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_branch_taken;
  logic             ex_is_load;
  logic             ex_is_div;
  logic [4:0]       ex_rd;
  logic             pc_wena;
  logic             ifid_wena;
  logic             idex_wena;
  logic             exmem_wena;
  logic             memwb_wena;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             div_start;
  logic             busy;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output mem_stall, id_rs, id_rt, id_uses_rs, id_uses_rt, id_branch_taken,
           ex_is_load, ex_is_div, ex_rd,
    input  pc_wena, ifid_wena, idex_wena, exmem_wena, memwb_wena,
           ifid_flush, idex_flush, exmem_flush, div_start, busy, stall_count
  );

  modport slave (
    input  mem_stall, id_rs, id_rt, id_uses_rs, id_uses_rt, id_branch_taken,
           ex_is_load, ex_is_div, ex_rd,
    output pc_wena, ifid_wena, idex_wena, exmem_wena, memwb_wena,
           ifid_flush, idex_flush, exmem_flush, div_start, busy, stall_count
  );
endinterface

// File: rtl/div_cycle_timer.sv
// Down-counter timing the divider; hit_one flags the last busy cycle.
module div_cycle_timer #(
  parameter int W        = 6,
  parameter int LOAD_VAL = 31
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic hit_one
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     cnt <= '0;
    else if (load)               cnt <= W'(LOAD_VAL);
    else if (dec && cnt != '0)   cnt <= cnt - W'(1);
  end

  assign hit_one = (cnt == W'(1));
endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken-branch
// squash, multi-cycle divider freeze and data-memory wait, plus a stall counter.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W      = 32
) (
  input logic              clk,
  input logic              rst,
  pipe_stall_ctrl_if.slave bus
);
  localparam int CW = $clog2(DIV_CYCLES + 1);

  state_t           state_r, state_d;
  logic [CNT_W-1:0] stall_cnt_r;
  logic             hit_one, tmr_load, tmr_dec, lu_hazard;
  logic             pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic             idex_fl, exmem_fl, start;

  assign lu_hazard = bus.ex_is_load &&
                     (src_match(bus.id_uses_rs, bus.id_rs, bus.ex_rd) ||
                      src_match(bus.id_uses_rt, bus.id_rt, bus.ex_rd));

  // The divider runs free, so the timer keeps counting through memory stalls.
  assign tmr_dec = (state_r == DIV_BUSY);

  always_comb begin
    pc_we    = 1'b1;
    ifid_we  = 1'b1;
    idex_we  = 1'b1;
    exmem_we = 1'b1;
    memwb_we = 1'b1;
    idex_fl  = 1'b0;
    exmem_fl = 1'b0;
    start    = 1'b0;
    tmr_load = 1'b0;
    state_d  = state_r;
    if (state_r == DIV_BUSY && hit_one) state_d = DIV_DONE;
    if (bus.mem_stall) begin
      {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b00000;
    end else begin
      unique case (state_r)
        RUN: begin
          if (bus.ex_is_div) begin
            {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b00000;
            start    = 1'b1;
            tmr_load = 1'b1;
            state_d  = DIV_BUSY;
          end else if (lu_hazard) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            idex_fl = 1'b1;
          end
        end
        // Older instructions drain through MEM/WB while EX/MEM fills with bubbles.
        DIV_BUSY: begin
          {pc_we, ifid_we, idex_we, exmem_we} = 4'b0000;
          exmem_fl = 1'b1;
        end
        DIV_DONE: state_d = RUN;
        default:  state_d = RUN;
      endcase
    end
  end

  div_cycle_timer #(
    .W        (CW),
    .LOAD_VAL (DIV_CYCLES - 1)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .dec     (tmr_dec),
    .hit_one (hit_one)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= RUN;
      stall_cnt_r <= '0;
    end else begin
      state_r <= state_d;
      if (!pc_we) stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end
  end

  // A held branch squashes the wrong-path fetch only when IF/ID actually loads.
  assign bus.ifid_flush  = bus.id_branch_taken && ifid_we;
  assign bus.pc_wena     = pc_we;
  assign bus.ifid_wena   = ifid_we;
  assign bus.idex_wena   = idex_we;
  assign bus.exmem_wena  = exmem_we;
  assign bus.memwb_wena  = memwb_we;
  assign bus.idex_flush  = idex_fl;
  assign bus.exmem_flush = exmem_fl;
  assign bus.div_start   = start;
  assign bus.busy        = (state_r != RUN);
  assign bus.stall_count = stall_cnt_r;
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl with DIV_CYCLES=4 and a 16-bit counter.
module tb_pipe_stall_ctrl;
  localparam int DIVC = 4;
  localparam int CW   = 16;

  typedef struct packed {
    logic       ms, ld, dv, br, urs, urt;
    logic [4:0] rs, rt, rd;
  } stim_t;

  // {pc,ifid,idex,exmem,memwb wena, ifid,idex,exmem flush, div_start, busy}
  localparam logic [9:0] NORM  = 10'b11111_000_0_0;
  localparam logic [9:0] LU    = 10'b00111_010_0_0;
  localparam logic [9:0] START = 10'b00000_000_1_0;
  localparam logic [9:0] DBUSY = 10'b00001_001_0_1;
  localparam logic [9:0] DDONE = 10'b11111_000_0_1;
  localparam logic [9:0] BR    = 10'b11111_100_0_0;
  localparam logic [9:0] MS    = 10'b00000_000_0_0;
  localparam logic [9:0] MSB   = 10'b00000_000_0_1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err    = 0;
  logic [CW-1:0] exp_sc = '0;
  logic [9:0]    sb[$];

  pipe_stall_ctrl_if #(.CNT_W(CW)) bus ();
  pipe_stall_ctrl #(.DIV_CYCLES(DIVC), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic stim_t mk(input logic ms, ld, dv, br, urs, urt,
                               input logic [4:0] rs, rt, rd);
    stim_t s;
    s.ms = ms; s.ld = ld; s.dv = dv; s.br = br; s.urs = urs; s.urt = urt;
    s.rs = rs; s.rt = rt; s.rd = rd;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    bus.mem_stall       = s.ms;
    bus.ex_is_load      = s.ld;
    bus.ex_is_div       = s.dv;
    bus.id_branch_taken = s.br;
    bus.id_uses_rs      = s.urs;
    bus.id_uses_rt      = s.urt;
    bus.id_rs           = s.rs;
    bus.id_rt           = s.rt;
    bus.ex_rd           = s.rd;
  endtask

  function automatic logic [9:0] outv();
    return {bus.pc_wena, bus.ifid_wena, bus.idex_wena, bus.exmem_wena, bus.memwb_wena,
            bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.div_start, bus.busy};
  endfunction

  stim_t IDLE;

  task automatic test_reset();
    apply(IDLE);
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    n_checks++;
    if (outv() !== NORM) begin
      n_err++; $display("FAIL reset_outputs got=%b exp=%b", outv(), NORM);
    end
    n_checks++;
    if (bus.stall_count !== '0) begin
      n_err++; $display("FAIL reset_count got=%0d exp=0", bus.stall_count);
    end
    @(posedge clk); #1 rst = 1'b0;
    exp_sc = '0;
    @(negedge clk);
    n_checks++;
    if (outv() !== NORM || bus.stall_count !== '0) begin
      n_err++; $display("FAIL post_reset got=%b cnt=%0d exp=%b cnt=0", outv(), bus.stall_count, NORM);
    end
  endtask

  task automatic test_load_use();
    stim_t st[6];
    logic [9:0] ex[6];
    logic [9:0] e;
    st[0] = mk(0,1,0,0,1,0, 5'd8, 5'd0, 5'd8); ex[0] = LU;
    st[1] = IDLE;                              ex[1] = NORM;
    st[2] = mk(0,1,0,0,1,0, 5'd0, 5'd0, 5'd0); ex[2] = NORM;
    st[3] = mk(0,1,0,0,0,1, 5'd3, 5'd5, 5'd5); ex[3] = LU;
    st[4] = mk(0,1,0,0,0,0, 5'd5, 5'd5, 5'd5); ex[4] = NORM;
    st[5] = mk(0,0,0,0,1,1, 5'd7, 5'd7, 5'd7); ex[5] = NORM;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 apply(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (outv() !== e) begin
        n_err++; $display("FAIL load_use[%0d] got=%b exp=%b", i, outv(), e);
      end
      n_checks++;
      if (bus.stall_count !== exp_sc) begin
        n_err++; $display("FAIL load_use_cnt[%0d] got=%0d exp=%0d", i, bus.stall_count, exp_sc);
      end
      if (!e[9]) exp_sc++;
    end
  endtask

  task automatic test_div();
    stim_t st[7];
    logic [9:0] ex[7];
    logic [9:0] e;
    logic [CW-1:0] base;
    int n_busy = 0;
    int n_frz  = 0;
    st[0] = mk(0,0,1,0,0,0, 0,0,0); ex[0] = START;
    for (int i = 1; i <= 3; i++) begin st[i] = st[0]; ex[i] = DBUSY; end
    st[4] = st[0]; ex[4] = DDONE;
    st[5] = IDLE;  ex[5] = NORM;
    st[6] = IDLE;  ex[6] = NORM;
    @(negedge clk) base = bus.stall_count;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1 apply(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      e = sb.pop_front();
      if (bus.busy === 1'b1) n_busy++;
      if (bus.pc_wena === 1'b0) n_frz++;
      n_checks++;
      if (outv() !== e) begin
        n_err++; $display("FAIL div[%0d] got=%b exp=%b", i, outv(), e);
      end
      n_checks++;
      if (bus.stall_count !== exp_sc) begin
        n_err++; $display("FAIL div_cnt[%0d] got=%0d exp=%0d", i, bus.stall_count, exp_sc);
      end
      if (!e[9]) exp_sc++;
    end
    n_checks++;
    if (n_busy != DIVC) begin
      n_err++; $display("FAIL div_busy_cycles got=%0d exp=%0d", n_busy, DIVC);
    end
    n_checks++;
    if (n_frz != DIVC || bus.stall_count - base !== CW'(DIVC)) begin
      n_err++; $display("FAIL div_stall_delta got=%0d frz=%0d exp=%0d", bus.stall_count - base, n_frz, DIVC);
    end
  endtask

  task automatic test_branch_hazard();
    stim_t st[4];
    logic [9:0] ex[4];
    logic [9:0] e;
    st[0] = mk(0,1,0,1,1,0, 5'd9, 5'd0, 5'd9); ex[0] = LU;
    st[1] = mk(0,0,0,1,1,0, 5'd9, 5'd0, 5'd9); ex[1] = BR;
    st[2] = mk(1,1,0,1,1,0, 5'd9, 5'd0, 5'd9); ex[2] = MS;
    st[3] = IDLE;                              ex[3] = NORM;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 apply(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (outv() !== e) begin
        n_err++; $display("FAIL branch[%0d] got=%b exp=%b", i, outv(), e);
      end
      n_checks++;
      if (bus.stall_count !== exp_sc) begin
        n_err++; $display("FAIL branch_cnt[%0d] got=%0d exp=%0d", i, bus.stall_count, exp_sc);
      end
      if (!e[9]) exp_sc++;
    end
  endtask

  task automatic test_mem_stall_div();
    stim_t st[8];
    logic [9:0] ex[8];
    logic [9:0] e;
    stim_t dv, dvm;
    dv  = mk(0,0,1,0,0,0, 0,0,0);
    dvm = mk(1,0,1,1,0,0, 0,0,0);
    st[0] = dv;   ex[0] = START;
    st[1] = dv;   ex[1] = DBUSY;
    st[2] = dvm;  ex[2] = MSB;
    st[3] = dvm;  ex[3] = MSB;
    st[4] = dvm;  ex[4] = MSB;
    st[5] = mk(0,0,1,1,0,0, 0,0,0); ex[5] = DDONE | 10'b00000_100_0_0;
    st[6] = IDLE; ex[6] = NORM;
    st[7] = IDLE; ex[7] = NORM;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1 apply(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (outv() !== e) begin
        n_err++; $display("FAIL mem_stall_div[%0d] got=%b exp=%b", i, outv(), e);
      end
      n_checks++;
      if (bus.stall_count !== exp_sc) begin
        n_err++; $display("FAIL mem_stall_cnt[%0d] got=%0d exp=%0d", i, bus.stall_count, exp_sc);
      end
      if (!e[9]) exp_sc++;
    end
  endtask

  task automatic test_reset_mid_div();
    logic [9:0] e;
    @(posedge clk); #1 apply(mk(0,0,1,0,0,0, 0,0,0)); sb.push_back(START);
    @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if (outv() !== e) begin
      n_err++; $display("FAIL rst_div_start got=%b exp=%b", outv(), e);
    end
    @(posedge clk); #1 sb.push_back(DBUSY);
    @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if (outv() !== e) begin
      n_err++; $display("FAIL rst_div_busy got=%b exp=%b", outv(), e);
    end
    #2 rst = 1'b1; apply(IDLE);
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.stall_count !== '0) begin
      n_err++; $display("FAIL rst_async got busy=%b cnt=%0d exp busy=0 cnt=0", bus.busy, bus.stall_count);
    end
    @(posedge clk); #1 rst = 1'b0;
    exp_sc = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 apply(IDLE); sb.push_back(NORM);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (outv() !== e || bus.stall_count !== exp_sc) begin
        n_err++; $display("FAIL rst_after[%0d] got=%b cnt=%0d exp=%b cnt=%0d", i, outv(), bus.stall_count, e, exp_sc);
      end
    end
  endtask

  initial begin
    IDLE = mk(0,0,0,0,0,0, 0,0,0);
    apply(IDLE);
    test_reset();
    test_load_use();
    test_div();
    test_branch_hazard();
    test_mem_stall_div();
    test_reset_mid_div();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
